apb_completer_regs: RTL and testbench
=====================================

APB_COMPLETER_REGS -- requirements
Module: apb_completer_regs

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning APB data width (multiple of 8).
REQ-003 SHALL have parameter NREGS, default 8, meaning register count; indices 0..NREGS-2 read/write, NREGS-1 read-only status.
REQ-004 SHALL have parameter WAIT_CYCLES, default 0, meaning wait states inserted per access (0..15).
REQ-005 SHALL use one clock; reset is asynchronous and active-low; ports: pclk  input  1  clock; presetn  input  1  async active-low reset.
REQ-006 SHALL have ports paddr, pprot[2:0], pnse, psel, penable, pwrite, pwdata, pstrb[DATA_WIDTH/8-1:0] as inputs, APB requester-driven request.
REQ-007 SHALL have ports pready (1), prdata (DATA_WIDTH), pslverr (1) as outputs, completer response.
REQ-008 SHALL have port hw_status  input  DATA_WIDTH  value returned for register NREGS-1.
REQ-009 SHALL have port reg_q  output  (NREGS-1)*DATA_WIDTH  flattened RW register contents, reg i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port reg_wr  output  NREGS-1  one-cycle pulse per RW register on a committed write.

Function
REQ-011 SHALL decode index = paddr >> log2(DATA_WIDTH/8); offset = byte address.
REQ-012 SHALL implement FSM IDLE, WAIT, DONE; IDLE->WAIT on psel & ~penable (setup) when WAIT_CYCLES>0, IDLE->DONE when WAIT_CYCLES==0.
REQ-013 SHALL load a wait counter with WAIT_CYCLES at the setup edge and decrement it in WAIT on each cycle with psel & penable; WAIT->DONE when counter reaches 1.
REQ-014 SHALL drive pready, prdata, pslverr from registers, all set at the edge entering DONE; pready low in IDLE and WAIT.
REQ-015 SHALL complete the transfer on the DONE cycle with psel & penable & pready; at that edge pready, pslverr, prdata clear to 0 and FSM -> IDLE.
REQ-016 Total latency: access phase lasts exactly WAIT_CYCLES+1 cycles; back-to-back setup immediately after completion SHALL be accepted with no idle cycle.
REQ-017 SHALL flag error (pslverr=1 in DONE) when: offset not word-aligned; index >= NREGS; or pwrite=1 to index NREGS-1.
REQ-018 On error SHALL not modify any register, not pulse reg_wr, and return prdata=0.
REQ-019 Write: at completion edge, for each byte lane b with pstrb[b]=1, reg[index] byte b <= pwdata byte b; other bytes unchanged; reg_wr[index] high for the following cycle only.
REQ-020 Write with pstrb=0 SHALL succeed (pslverr=0), change nothing, still pulse reg_wr.
REQ-021 Read: prdata SHALL be reg[index] or hw_status as sampled at the edge entering DONE; pstrb ignored on reads.
REQ-022 Address/control SHALL be captured at the setup edge; changes during access phase are ignored.
REQ-023 If psel drops before completion (protocol abort), FSM SHALL return to IDLE next edge with no write and pready=0.
REQ-024 pprot and pnse SHALL be accepted and ignored.

Reset
REQ-025 presetn low SHALL asynchronously clear FSM to IDLE, counter, pready, pslverr, prdata, reg_q, and reg_wr to 0, including mid-transfer; the in-flight write SHALL be lost.

Structure
REQ-026 SHALL place the FSM state enum and the error-decode constants in shared package apb_pkg, reused by the requester.
REQ-027 SHALL keep the register array in one sub-module apb_reg_bank (byte-strobe write, read mux); FSM and decode remain in the top module.

Verification
REQ-028 WAIT_CYCLES=0: write 0xDEADBEEF, pstrb=0xF to 0x04 -> pready in first access cycle, pslverr=0, reg_q reg1=0xDEADBEEF, reg_wr=0b0000010 one cycle.
REQ-029 Partial strobe: reg1=0xDEADBEEF, write 0x11223344 pstrb=0x5 -> reg1=0xDE22BE44; read 0x04 returns 0xDE22BE44.
REQ-030 WAIT_CYCLES=3: read 0x1C with hw_status=0xA5A5 -> pready high in 4th access cycle, prdata=0x0000A5A5, pslverr=0.
REQ-031 Errors: write 0x1C, write 0x20, read 0x02 -> each pslverr=1, prdata=0, no reg change, no reg_wr.
REQ-032 Back-to-back write 0x00 then read 0x00 with no idle cycle -> read returns written data; presetn pulsed during a WAIT access -> all outputs 0, register unchanged.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer FSM states and error-decode causes,
// used by both the completer and the requester side of the bus.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } apb_state_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_ALIGN = 2'd1,
        ERR_RANGE = 2'd2,
        ERR_RO    = 2'd3
    } apb_err_e;

    localparam int WAIT_CNT_W = 4;

    // Number of low address bits that select a byte within one data word.
    function automatic int addr_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// Register array behind the APB completer: NREGS-1 byte-strobed RW words
// plus a read-only status word supplied by hardware.
module apb_reg_bank
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NREGS      = 8,
    parameter int IDX_W      = 3
) (
    input  logic                            pclk,
    input  logic                            presetn,
    input  logic                            wr_en,
    input  logic [IDX_W-1:0]                wr_idx,
    input  logic [DATA_WIDTH-1:0]           wr_data,
    input  logic [DATA_WIDTH/8-1:0]         wr_strb,
    input  logic [IDX_W-1:0]                rd_idx,
    input  logic [DATA_WIDTH-1:0]           hw_status,
    output logic [DATA_WIDTH-1:0]           rd_data,
    output logic [(NREGS-1)*DATA_WIDTH-1:0] reg_q,
    output logic [NREGS-2:0]                reg_wr
);

    localparam int BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] regs [NREGS-1];

    // NOTE: the register array is reset on purpose -- reg_q is a visible
    // output and must read as zero straight out of reset.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < NREGS - 1; i++) begin
                regs[i] <= '0;
            end
            reg_wr <= '0;
        end else begin
            reg_wr <= '0;
            if (wr_en) begin
                for (int i = 0; i < NREGS - 1; i++) begin
                    if (wr_idx == IDX_W'(i)) begin
                        reg_wr[i] <= 1'b1;
                        for (int b = 0; b < BYTES; b++) begin
                            if (wr_strb[b]) begin
                                regs[i][b*8 +: 8] <= wr_data[b*8 +: 8];
                            end
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_idx == IDX_W'(NREGS - 1)) begin
            rd_data = hw_status;
        end else begin
            for (int i = 0; i < NREGS - 1; i++) begin
                if (rd_idx == IDX_W'(i)) begin
                    rd_data = regs[i];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NREGS - 1; i++) begin
            reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
        end
    end

endmodule

// File: rtl/apb_completer_regs.sv
// APB completer with configurable wait states: transfer FSM and address
// decode here, register storage in apb_reg_bank.
module apb_completer_regs
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NREGS       = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                            pclk,
    input  logic                            presetn,
    input  logic [ADDR_WIDTH-1:0]           paddr,
    input  logic [2:0]                      pprot,
    input  logic                            pnse,
    input  logic                            psel,
    input  logic                            penable,
    input  logic                            pwrite,
    input  logic [DATA_WIDTH-1:0]           pwdata,
    input  logic [DATA_WIDTH/8-1:0]         pstrb,
    output logic                            pready,
    output logic [DATA_WIDTH-1:0]           prdata,
    output logic                            pslverr,
    input  logic [DATA_WIDTH-1:0]           hw_status,
    output logic [(NREGS-1)*DATA_WIDTH-1:0] reg_q,
    output logic [NREGS-2:0]                reg_wr
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LSB   = addr_lsb(DATA_WIDTH);
    localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] NREGS_A    = ADDR_WIDTH'(NREGS);
    localparam logic [ADDR_WIDTH-1:0] RO_IDX_A   = ADDR_WIDTH'(NREGS - 1);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD  = WAIT_CNT_W'(WAIT_CYCLES);

    apb_state_e              state;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
    logic [ADDR_WIDTH-1:0]   cap_addr;
    logic                    cap_write;
    logic [DATA_WIDTH-1:0]   cap_wdata;
    logic [BYTES-1:0]        cap_strb;

    logic                    setup;
    logic [ADDR_WIDTH-1:0]   dec_addr;
    logic                    dec_write;
    logic [ADDR_WIDTH-1:0]   dec_idx;
    apb_err_e                err_cause;
    logic                    rsp_err;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic [DATA_WIDTH-1:0]   rsp_data;
    logic                    commit;
    logic                    unused_bus;

    assign unused_bus = ^{pprot, pnse};
    assign setup      = (state == ST_IDLE) && psel && !penable;

    // In IDLE the live bus is decoded so a zero-wait access can respond at
    // its setup edge; afterwards only the captured request matters.
    always_comb begin
        dec_addr  = cap_addr;
        dec_write = cap_write;
        if (state == ST_IDLE) begin
            dec_addr  = paddr;
            dec_write = pwrite;
        end
    end

    assign dec_idx = dec_addr >> LSB;

    always_comb begin
        err_cause = ERR_NONE;
        if ((dec_addr & ALIGN_MASK) != '0) begin
            err_cause = ERR_ALIGN;
        end else if (dec_idx >= NREGS_A) begin
            err_cause = ERR_RANGE;
        end else if (dec_write && (dec_idx == RO_IDX_A)) begin
            err_cause = ERR_RO;
        end
    end

    assign rsp_err  = (err_cause != ERR_NONE);
    assign rsp_data = (rsp_err || dec_write) ? '0 : rd_data;
    assign commit   = (state == ST_DONE) && psel && penable && cap_write && !rsp_err;

    // NOTE: all state below uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            cap_addr  <= '0;
            cap_write <= 1'b0;
            cap_wdata <= '0;
            cap_strb  <= '0;
            pready    <= 1'b0;
            pslverr   <= 1'b0;
            prdata    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (setup) begin
                        cap_addr  <= paddr;
                        cap_write <= pwrite;
                        cap_wdata <= pwdata;
                        cap_strb  <= pstrb;
                        wait_cnt  <= WAIT_LOAD;
                        if (WAIT_CYCLES == 0) begin
                            state   <= ST_DONE;
                            pready  <= 1'b1;
                            pslverr <= rsp_err;
                            prdata  <= rsp_data;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!psel) begin
                        state    <= ST_IDLE;
                        wait_cnt <= '0;
                    end else if (penable) begin
                        if (wait_cnt <= WAIT_CNT_W'(1)) begin
                            state    <= ST_DONE;
                            wait_cnt <= '0;
                            pready   <= 1'b1;
                            pslverr  <= rsp_err;
                            prdata   <= rsp_data;
                        end else begin
                            wait_cnt <= wait_cnt - WAIT_CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    // Completion and abort both return to IDLE; only a
                    // completion commits a write (see commit).
                    if (!psel || penable) begin
                        state   <= ST_IDLE;
                        pready  <= 1'b0;
                        pslverr <= 1'b0;
                        prdata  <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    apb_reg_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .NREGS      (NREGS),
        .IDX_W      (IDX_W)
    ) u_reg_bank (
        .pclk      (pclk),
        .presetn   (presetn),
        .wr_en     (commit),
        .wr_idx    (IDX_W'(dec_idx)),
        .wr_data   (cap_wdata),
        .wr_strb   (cap_strb),
        .rd_idx    (IDX_W'(dec_idx)),
        .hw_status (hw_status),
        .rd_data   (rd_data),
        .reg_q     (reg_q),
        .reg_wr    (reg_wr)
    );

endmodule

// File: tb/tb_apb_completer_regs.sv
// Randomised self-checking bench: a zero-wait and a three-wait completer,
// each checked every cycle against a transaction-level register model.
module tb_apb_completer_regs;

    logic              clk = 1'b0;
    logic [1:0]        presetn;
    logic [1:0][31:0]  paddr;
    logic [1:0][2:0]   pprot;
    logic [1:0]        pnse;
    logic [1:0]        psel;
    logic [1:0]        penable;
    logic [1:0]        pwrite;
    logic [1:0][31:0]  pwdata;
    logic [1:0][3:0]   pstrb;
    logic [31:0]       hw_status;
    wire  [1:0]        pready;
    wire  [1:0][31:0]  prdata;
    wire  [1:0]        pslverr;
    wire  [1:0][223:0] reg_q;
    wire  [1:0][6:0]   reg_wr;

    int errors = 0;
    int checks = 0;
    bit cmp_on = 1'b0;

    logic [31:0] m_reg      [2][8];
    logic        exp_pready [2];
    logic [31:0] exp_prdata [2];
    logic        exp_pslverr[2];
    logic [6:0]  exp_wr     [2];

    int          got_k;
    logic [31:0] got_prdata;
    logic        got_pslverr;

    always #5 clk = ~clk;

    apb_completer_regs #(.WAIT_CYCLES(0)) dut0 (
        .pclk(clk), .presetn(presetn[0]), .paddr(paddr[0]), .pprot(pprot[0]),
        .pnse(pnse[0]), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
        .pwdata(pwdata[0]), .pstrb(pstrb[0]), .pready(pready[0]), .prdata(prdata[0]),
        .pslverr(pslverr[0]), .hw_status(hw_status), .reg_q(reg_q[0]), .reg_wr(reg_wr[0])
    );

    apb_completer_regs #(.WAIT_CYCLES(3)) dut3 (
        .pclk(clk), .presetn(presetn[1]), .paddr(paddr[1]), .pprot(pprot[1]),
        .pnse(pnse[1]), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
        .pwdata(pwdata[1]), .pstrb(pstrb[1]), .pready(pready[1]), .prdata(prdata[1]),
        .pslverr(pslverr[1]), .hw_status(hw_status), .reg_q(reg_q[1]), .reg_wr(reg_wr[1])
    );

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    function automatic logic [223:0] pack(input int d);
        logic [223:0] v;
        for (int i = 0; i < 7; i++) v[i*32 +: 32] = m_reg[d][i];
        return v;
    endfunction

    task automatic clear_outputs(input int d);
        exp_pready[d]  = 1'b0;
        exp_prdata[d]  = '0;
        exp_pslverr[d] = 1'b0;
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("pready%0d", d),  pready[d],  exp_pready[d]);
                check($sformatf("prdata%0d", d),  prdata[d],  exp_prdata[d]);
                check($sformatf("pslverr%0d", d), pslverr[d], exp_pslverr[d]);
                check($sformatf("reg_q%0d", d),   reg_q[d],   pack(d));
                check($sformatf("reg_wr%0d", d),  reg_wr[d],  exp_wr[d]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        exp_wr[0] = '0;
        exp_wr[1] = '0;
    endtask

    // One APB transfer on completer d. abort_at / rst_at name the access
    // cycle (1-based) at which psel is dropped or presetn is pulsed; 0 = never.
    task automatic apb(input int d, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb,
                       input int abort_at, input int rst_at, input bit scramble);
        int          w;
        bit          err;
        logic [31:0] idx;
        logic [31:0] rsp;
        w   = (d == 0) ? 0 : 3;
        idx = addr / 4;
        err = (addr % 4 != 0) || (idx >= 8) || (wr && idx == 7);
        rsp = (err || wr) ? 32'h0 : ((idx == 7) ? hw_status : m_reg[d][idx[2:0]]);
        got_k = 0;
        got_prdata = 'x;
        got_pslverr = 1'bx;
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr;
        pwdata[d] = data; pstrb[d] = strb;
        pprot[d] = 3'($urandom); pnse[d] = 1'($urandom);
        for (int k = 1; k <= w + 1; k++) begin
            tick();
            penable[d] = 1'b1;
            if (scramble) begin
                paddr[d]  = $urandom;
                pwrite[d] = 1'($urandom);
            end
            exp_pready[d]  = (k == w + 1);
            exp_prdata[d]  = (k == w + 1) ? rsp : 32'h0;
            exp_pslverr[d] = (k == w + 1) && err;
            if (pready[d] === 1'b1 && got_k == 0) begin
                got_k = k;
                got_prdata = prdata[d];
                got_pslverr = pslverr[d];
            end
            if (k == rst_at) begin
                presetn[d] = 1'b0;
                psel[d] = 1'b0; penable[d] = 1'b0;
                for (int i = 0; i < 8; i++) m_reg[d][i] = '0;
                clear_outputs(d);
                #1;
                check("async_rst_pready", pready[d], 1'b0);
                check("async_rst_reg_q", reg_q[d], 224'h0);
                tick();
                presetn[d] = 1'b1;
                return;
            end
            if (k == abort_at) begin
                psel[d] = 1'b0; penable[d] = 1'b0;
                tick();
                clear_outputs(d);
                return;
            end
        end
        tick();
        clear_outputs(d);
        if (!err && wr) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) m_reg[d][idx[2:0]][b*8 +: 8] = data[b*8 +: 8];
            exp_wr[d] = 7'(1 << idx);
        end
        psel[d] = 1'b0; penable[d] = 1'b0;
    endtask

    task automatic rand_run(input int d, input int n);
        bit          wr;
        int          r;
        logic [31:0] addr;
        int          ab;
        for (int t = 0; t < n; t++) begin
            wr = 1'($urandom);
            r  = $urandom_range(0, 15);
            if (r < 12)      addr = 4 * $urandom_range(0, 7);
            else if (r < 14) addr = $urandom_range(0, 40);
            else             addr = 4 * $urandom_range(8, 12);
            ab = ($urandom_range(0, 7) == 0) ? $urandom_range(1, (d == 0) ? 1 : 4) : 0;
            hw_status = $urandom;
            apb(d, wr, addr, $urandom, 4'($urandom), ab, 0, 1'($urandom));
            if ($urandom_range(0, 2) != 0) tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        presetn = 2'b00;
        paddr = '0; pprot = '0; pnse = '0; psel = '0; penable = '0;
        pwrite = '0; pwdata = '0; pstrb = '0; hw_status = '0;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) m_reg[d][i] = '0;
            clear_outputs(d);
            exp_wr[d] = '0;
        end
        repeat (2) tick();
        cmp_on = 1'b1;
        tick();
        presetn = 2'b11;
        check("reset_reg_q0", reg_q[0], 224'h0);
        check("reset_pready1", pready[1], 1'b0);

        // Zero-wait full write to word 1.
        apb(0, 1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 1'b0);
        check("w0_latency", got_k, 1);
        check("w0_pslverr", got_pslverr, 1'b0);
        check("w0_reg1", reg_q[0][63:32], 32'hDEADBEEF);
        check("w0_reg_wr", reg_wr[0], 7'b0000010);
        tick();

        // Partial strobe then read back.
        apb(0, 1'b1, 32'h04, 32'h11223344, 4'h5, 0, 0, 1'b0);
        tick();
        apb(0, 1'b0, 32'h04, 32'h0, 4'h0, 0, 0, 1'b0);
        check("strb_read", got_prdata, 32'hDE22BE44);
        tick();

        // Empty-strobe write: succeeds, no change, still pulses.
        apb(0, 1'b1, 32'h04, 32'hFFFFFFFF, 4'h0, 0, 0, 1'b0);
        check("strb0_reg_wr", reg_wr[0], 7'b0000010);
        check("strb0_reg1", reg_q[0][63:32], 32'hDE22BE44);
        tick();

        // Error cases.
        apb(0, 1'b1, 32'h1C, 32'h12345678, 4'hF, 0, 0, 1'b0);
        check("err_ro_pslverr", got_pslverr, 1'b1);
        check("err_ro_reg_wr", reg_wr[0], 7'b0);
        apb(0, 1'b1, 32'h20, 32'h12345678, 4'hF, 0, 0, 1'b0);
        check("err_range_pslverr", got_pslverr, 1'b1);
        hw_status = 32'hCAFEF00D;
        apb(0, 1'b0, 32'h02, 32'h0, 4'hF, 0, 0, 1'b0);
        check("err_align_pslverr", got_pslverr, 1'b1);
        check("err_align_prdata", got_prdata, 32'h0);
        tick();

        // Back-to-back write then read with no idle cycle.
        apb(0, 1'b1, 32'h00, 32'h5A5A0F0F, 4'hF, 0, 0, 1'b0);
        apb(0, 1'b0, 32'h00, 32'h0, 4'h0, 0, 0, 1'b0);
        check("b2b_read", got_prdata, 32'h5A5A0F0F);
        tick();

        rand_run(0, 60);

        // Three wait states: status register read.
        hw_status = 32'h0000A5A5;
        apb(1, 1'b0, 32'h1C, 32'h0, 4'h0, 0, 0, 1'b0);
        check("w3_latency", got_k, 4);
        check("w3_prdata", got_prdata, 32'h0000A5A5);
        check("w3_pslverr", got_pslverr, 1'b0);
        tick();

        rand_run(1, 40);

        // Reset in the middle of a waited write: write is lost.
        apb(1, 1'b1, 32'h08, 32'h87654321, 4'hF, 0, 0, 1'b0);
        tick();
        apb(1, 1'b1, 32'h00, 32'h12345678, 4'hF, 0, 2, 1'b0);
        tick();
        check("rst_reg_q1", reg_q[1], 224'h0);
        apb(1, 1'b0, 32'h00, 32'h0, 4'h0, 0, 0, 1'b0);
        check("rst_read_lost", got_prdata, 32'h0);
        tick();
        tick();

        cmp_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
